// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg
//   Shared definitions for the UART transmit scheduler.
//   - FSM state encoding (3-bit constants, legacy-compatible)
//   - Default tag base byte, used only when UART_SCHED_TAG_EN is defined
//   - onehot8_to_idx: converts a one-hot grant (zero-padded to 8 bits) into an index
package uart_sched_pkg;

  localparam logic [2:0] S_SYNC = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_TAG  = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;

  // One-hot input is assumed; OR-ing the indices of the set bits yields the index.
  function automatic logic [2:0] onehot8_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = idx | (oh[i] ? 3'(i) : 3'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_pick.sv
// rr_pick
//   Combinational rotate-priority picker.
//   Ports:
//     req_i   [NUM_REQ]  request vector
//     ptr_i   [3]        requester with highest priority (must be < NUM_REQ)
//     grant_o [NUM_REQ]  one-hot winner: first set request at or after ptr_i, wrapping
//     found_o            at least one request is set
module rr_pick #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               found_o
);

  logic [NUM_REQ-1:0]   rot_s;
  logic [NUM_REQ-1:0]   first_s;
  logic [2*NUM_REQ-1:0] unrot_s;
  logic                 taken_s;

  // Rotate so the pointer position lands on bit 0, then take the lowest set bit.
  always_comb begin
    rot_s   = NUM_REQ'({req_i, req_i} >> ptr_i);
    first_s = '0;
    taken_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!taken_s && rot_s[k]) begin
        first_s[k] = 1'b1;
        taken_s    = 1'b1;
      end else begin
        first_s[k] = 1'b0;
      end
    end
  end

  // Rotate the winner back; the upper half holds positions that wrapped past NUM_REQ-1.
  always_comb begin
    unrot_s = {{NUM_REQ{1'b0}}, first_s} << ptr_i;
    grant_o = unrot_s[NUM_REQ-1:0] | unrot_s[2*NUM_REQ-1:NUM_REQ];
    found_o = |req_i;
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Round-robin, packet-locked scheduler sharing one 8N1 UART transmitter among
//   NUM_REQ byte-stream requesters. A grant holds until a Last byte or MAX_BURST
//   bytes, then the pointer rotates past the owner. One DV per byte, paced on the
//   transmitter's Active/Done.
//   Optional macro UART_SCHED_TAG_EN: each new grant first sends TAG_BASE|g.
//   Ports:
//     i_Clock, i_Reset            clock, synchronous active-high reset
//     i_Req_Valid/Byte/Last       per-requester byte offer (byte r at [8r+:8])
//     o_Req_Ready                 1-cycle accept pulse per requester
//     o_Grant, o_Busy             current one-hot owner, any owner held
//     o_Tx_DV, o_Tx_Byte          transmitter start pulse and byte
//     i_Tx_Active, i_Tx_Done      transmitter status (Done: rising edge counts)
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 16
`ifdef UART_SCHED_TAG_EN
  , parameter logic [7:0] TAG_BASE = TAG_BASE_DEFAULT
`endif
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic [NUM_REQ-1:0]     i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
  input  logic [NUM_REQ-1:0]     i_Req_Last,
  output logic [NUM_REQ-1:0]     o_Req_Ready,
  output logic [NUM_REQ-1:0]     o_Grant,
  output logic                   o_Busy,
  output logic                   o_Tx_DV,
  output logic [7:0]             o_Tx_Byte,
  input  logic                   i_Tx_Active,
  input  logic                   i_Tx_Done
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
  localparam logic [2:0] LAST_IDX    = 3'(NUM_REQ - 1);

  logic [2:0]         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [2:0]         g_idx_q, g_idx_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [7:0]         count_q, count_d;
  logic               last_q, last_d;
  logic               done_d_q;
  logic               tx_dv_q, tx_dv_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               busy_q, busy_d;
`ifdef UART_SCHED_TAG_EN
  logic               tag_q, tag_d;
`endif

  logic [NUM_REQ-1:0] pick_grant_s;
  logic               pick_found_s;
  logic [7:0]         pick_oh8_s;
  logic               valid_g_s;
  logic [7:0]         byte_g_s;
  logic               last_g_s;
  logic               done_rise_s;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req_i   (i_Req_Valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant_s),
    .found_o (pick_found_s)
  );

  // Owner's offer (grant is one-hot, so OR-merging selects it) and Done edge.
  always_comb begin
    pick_oh8_s = 8'h00;
    byte_g_s   = 8'h00;
    last_g_s   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_oh8_s[i] = pick_grant_s[i];
      byte_g_s      = byte_g_s | (i_Req_Byte[8*i +: 8] & {8{grant_q[i]}});
      last_g_s      = last_g_s | (i_Req_Last[i] & grant_q[i]);
    end
    valid_g_s   = |(i_Req_Valid & grant_q);
    done_rise_s = i_Tx_Done & ~done_d_q;
  end

  // Scheduler FSM next-state logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    g_idx_d   = g_idx_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    last_d    = last_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    ready_d   = '0;
`ifdef UART_SCHED_TAG_EN
    tag_d     = tag_q;
`endif
    case (state_q)
      S_SYNC: begin
        // Leave only once a transmitter byte started before reset has fully drained.
        if (!i_Tx_Active && !i_Tx_Done) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SYNC;
        end
      end
      S_IDLE: begin
        if (pick_found_s) begin
          grant_d = pick_grant_s;
          g_idx_d = onehot8_to_idx(pick_oh8_s);
          count_d = 8'd0;
`ifdef UART_SCHED_TAG_EN
          state_d = S_TAG;
`else
          state_d = S_SEND;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
`ifdef UART_SCHED_TAG_EN
      S_TAG: begin
        if (!i_Tx_Active) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = TAG_BASE | {5'b00000, g_idx_q};
          tag_d     = 1'b1;
          state_d   = S_WAIT;
        end else begin
          state_d = S_TAG;
        end
      end
`endif
      S_SEND: begin
        // A dropped Valid simply parks here with the grant held.
        if (valid_g_s && !i_Tx_Active) begin
          ready_d   = grant_q;
          tx_dv_d   = 1'b1;
          tx_byte_d = byte_g_s;
          last_d    = last_g_s;
          count_d   = count_q + 8'd1;
          state_d   = S_WAIT;
        end else begin
          state_d = S_SEND;
        end
      end
      S_WAIT: begin
        if (done_rise_s) begin
          state_d = S_GAP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_GAP: begin
`ifdef UART_SCHED_TAG_EN
        if (tag_q) begin
          tag_d   = 1'b0;
          state_d = S_SEND;
        end else
`endif
        if (last_q || (count_q == MAX_BURST_C)) begin
          grant_d = '0;
          count_d = 8'd0;
          ptr_d   = (g_idx_q == LAST_IDX) ? 3'd0 : (g_idx_q + 3'd1);
          state_d = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_SYNC;
      end
    endcase
    busy_d = |grant_d;
  end

  // State and output registers; reset drops the grant at once and resynchronises.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_SYNC;
      grant_q   <= '0;
      g_idx_q   <= 3'd0;
      ptr_q     <= 3'd0;
      count_q   <= 8'd0;
      last_q    <= 1'b0;
      done_d_q  <= 1'b0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
      ready_q   <= '0;
      busy_q    <= 1'b0;
`ifdef UART_SCHED_TAG_EN
      tag_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      g_idx_q   <= g_idx_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      last_q    <= last_d;
      done_d_q  <= i_Tx_Done;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef UART_SCHED_TAG_EN
      tag_q     <= tag_d;
`endif
    end
  end

  assign o_Req_Ready = ready_q;
  assign o_Grant     = grant_q;
  assign o_Busy      = busy_q;
  assign o_Tx_DV     = tx_dv_q;
  assign o_Tx_Byte   = tx_byte_q;

endmodule
